instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  rising-edge system clock; all state changes on this edge.
REQ-003 reset  input  1  asynchronous, active-high reset; forces all state to reset values immediately.
REQ-004 mem_req  output  1  instruction-memory read request, held until mem_ack.
REQ-005 mem_addr  output  32  word address of the request; stable while mem_req=1 and mem_ack=0.
REQ-006 mem_ack  input  1  one-cycle strobe; mem_rdata valid in the same cycle.
REQ-007 mem_rdata  input  32  instruction word returned by memory.
REQ-008 branch_taken  input  1  redirect strobe from execute stage.
REQ-009 branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-010 instr_out  output  32  registered instruction word for decode and the immediate generator.
REQ-011 instr_pc  output  32  address from which instr_out was fetched.
REQ-012 instr_valid  output  1  instr_out/instr_pc hold a live instruction.
REQ-013 instr_ready  input  1  decode accepts instr_out this cycle when instr_valid=1.

Function
REQ-014 The block SHALL implement three states: FETCH, DRAIN, HOLD.
REQ-015 mem_req SHALL be 1 in FETCH and DRAIN, 0 in HOLD and while reset=1; mem_addr SHALL equal pc in FETCH and DRAIN.
REQ-016 FETCH, mem_ack=1, branch_taken=0: instr_out<=mem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, go HOLD (ack cycle N -> instr_valid=1 in cycle N+1).
REQ-017 FETCH, mem_ack=1, branch_taken=1: discard mem_rdata, pc<=branch_target, stay FETCH, instr_valid stays 0.
REQ-018 FETCH, mem_ack=0, branch_taken=1: redirect_pc<=branch_target, go DRAIN; pc unchanged so mem_addr stays stable.
REQ-019 DRAIN: keep requesting old pc; a further branch_taken overwrites redirect_pc; on mem_ack discard mem_rdata, pc<=redirect_pc (or branch_target if branch_taken same cycle), go FETCH.
REQ-020 HOLD, branch_taken=1: instr_valid<=0, pc<=branch_target, go FETCH; redirect has priority over instr_ready.
REQ-021 HOLD, branch_taken=0, instr_ready=1: handshake completes, instr_valid<=0, go FETCH.
REQ-022 HOLD, instr_ready=0: instr_out, instr_pc, instr_valid SHALL hold unchanged.
REQ-023 Every value loaded into pc or redirect_pc SHALL have bits [1:0] forced to 2'b00.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-025 mem_ack received in HOLD SHALL be ignored.
REQ-026 Peak throughput: one instruction per two cycles (ack cycle, accept cycle) with zero-wait memory.

Reset
REQ-027 On reset=1: state=FETCH, pc=RESET_VECTOR, redirect_pc=0, instr_out=0, instr_pc=0, instr_valid=0, mem_req=0.
REQ-028 First cycle after reset deasserts: mem_req=1, mem_addr=RESET_VECTOR.
REQ-029 Reset asserted mid-request or in HOLD SHALL abandon the transaction and drop instr_valid in the same cycle, without waiting for mem_ack or the clock edge.

Verification
REQ-030 Reset, zero-wait memory returning 32'h00500093 at 0, instr_ready=1 -> instr_out=32'h00500093, instr_pc=0, next mem_addr=4.
REQ-031 mem_ack delayed 3 cycles -> mem_addr constant at 8 throughout, instr_valid=1 only the cycle after ack.
REQ-032 instr_ready=0 for 4 cycles in HOLD -> instr_out/instr_pc stable, mem_req=0; accept, then mem_req=1 at pc+4.
REQ-033 branch_taken target 32'h00000103 during pending fetch of 0x10 -> request at 0x10 held to ack, data dropped, next mem_addr=32'h00000100, instr_valid never 1 for 0x10.
REQ-034 branch_taken with instr_ready=1 in HOLD -> instruction dropped, next mem_addr=branch_target.
REQ-035 RESET_VECTOR=32'hFFFFFFFC -> first instr_pc=32'hFFFFFFFC, following mem_addr=0; reset asserted mid-wait -> mem_req=0 and instr_valid=0 immediately.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, branch redirect and decode handshake.
// Decode handshake: an instruction transfers on a rising edge where instr_valid=1 and instr_ready=1.
interface instruction_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output mem_req, mem_addr, instr_out, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, branch_taken, branch_target, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr_out, instr_pc, instr_valid,
    output mem_ack, mem_rdata, branch_taken, branch_target, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: requests pc, registers the returned word for decode,
// and handles branch redirects, including ones that arrive while a memory read is still pending.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_fetch_if.master   bus,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] redirect_pc, redirect_pc_n;
  logic [31:0] instr_out, instr_out_n;
  logic [31:0] instr_pc, instr_pc_n;
  logic        instr_valid, instr_valid_n;
  logic [31:0] target_aligned;

  assign target_aligned = {bus.branch_target[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_VECTOR;
      redirect_pc <= 32'h0;
      instr_out   <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      redirect_pc <= redirect_pc_n;
      instr_out   <= instr_out_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    redirect_pc_n = redirect_pc;
    instr_out_n   = instr_out;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    unique case (state)
      FETCH: begin
        if (bus.mem_ack) begin
          if (bus.branch_taken) begin
            pc_n = target_aligned;
          end else begin
            instr_out_n   = bus.mem_rdata;
            instr_pc_n    = pc;
            pc_n          = pc + 32'd4;
            instr_valid_n = 1'b1;
            state_n       = HOLD;
          end
        end else if (bus.branch_taken) begin
          // The read at pc must complete before redirecting, so park the target.
          redirect_pc_n = target_aligned;
          state_n       = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mem_ack) begin
          pc_n    = bus.branch_taken ? target_aligned : redirect_pc;
          state_n = FETCH;
        end else if (bus.branch_taken) begin
          redirect_pc_n = target_aligned;
        end
      end
      HOLD: begin
        // A redirect kills the held instruction even if decode is accepting it.
        if (bus.branch_taken) begin
          instr_valid_n = 1'b0;
          pc_n          = target_aligned;
          state_n       = FETCH;
        end else if (bus.instr_ready) begin
          instr_valid_n = 1'b0;
          state_n       = FETCH;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  assign bus.mem_req     = !reset && (state != HOLD);
  assign bus.mem_addr    = pc;
  assign bus.instr_out   = instr_out;
  assign bus.instr_pc    = instr_pc;
  assign bus.instr_valid = instr_valid;
  assign fsm_state       = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one instance at the default reset vector, one at 0xFFFFFFFC.
module tb_instruction_fetch;

  logic clk;
  logic rst_a;
  logic rst_b;
  logic [1:0] state_a;
  logic [1:0] state_b;
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  localparam logic [31:0] D0 = 32'h00500093;
  localparam logic [31:0] D1 = 32'h00100113;
  localparam logic [31:0] D2 = 32'h002081b3;
  localparam logic [31:0] D3 = 32'h40310233;
  localparam logic [31:0] D4 = 32'h0000006f;
  localparam logic [31:0] D5 = 32'h00c000ef;
  localparam logic [31:0] JUNK = 32'hdeadbeef;

  instruction_fetch_if bus_a ();
  instruction_fetch_if bus_b ();

  instruction_fetch dut_a (
    .clk       (clk),
    .reset     (rst_a),
    .bus       (bus_a),
    .fsm_state (state_a)
  );

  instruction_fetch #(.RESET_VECTOR(32'hFFFFFFFC)) dut_b (
    .clk       (clk),
    .reset     (rst_b),
    .bus       (bus_b),
    .fsm_state (state_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic ack, input logic [31:0] rdata, input logic br,
                         input logic [31:0] tgt, input logic rdy);
    bus_a.mem_ack       = ack;
    bus_a.mem_rdata     = rdata;
    bus_a.branch_taken  = br;
    bus_a.branch_target = tgt;
    bus_a.instr_ready   = rdy;
  endtask

  task automatic drive_b(input logic ack, input logic [31:0] rdata, input logic rdy);
    bus_b.mem_ack       = ack;
    bus_b.mem_rdata     = rdata;
    bus_b.branch_taken  = 1'b0;
    bus_b.branch_target = 32'h0;
    bus_b.instr_ready   = rdy;
  endtask

  task automatic expect_a(input string tag, input logic req, input logic [31:0] addr,
                          input logic valid);
    check({tag, "_req"}, 64'(bus_a.mem_req), 64'(req));
    if (req) check({tag, "_addr"}, 64'(bus_a.mem_addr), 64'(addr));
    check({tag, "_valid"}, 64'(bus_a.instr_valid), 64'(valid));
  endtask

  // scoreboard: every instruction decode accepts from dut_a must match the expected queue
  initial begin
    logic [63:0] exp_item;
    forever begin
      @(negedge clk);
      #1;
      if (bus_a.instr_valid && bus_a.instr_ready && !bus_a.branch_taken) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {bus_a.instr_pc, bus_a.instr_out}, 64'h0);
        end else begin
          exp_item = exp_q.pop_front();
          check("sb_accept", {bus_a.instr_pc, bus_a.instr_out}, exp_item);
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive_b(1'b0, 32'h0, 1'b0);

    // reset values and first request
    tick();
    check("rst_req", 64'(bus_a.mem_req), 64'd0);
    check("rst_valid", 64'(bus_a.instr_valid), 64'd0);
    check("rst_instr_out", 64'(bus_a.instr_out), 64'd0);
    check("rst_instr_pc", 64'(bus_a.instr_pc), 64'd0);
    check("rst_state", 64'(state_a), 64'd0);
    rst_a = 1'b0;
    #1;
    expect_a("first_req", 1'b1, 32'h0, 1'b0);
    drive_a(1'b1, D0, 1'b0, 32'h0, 1'b1);
    exp_q.push_back({32'h0, D0});

    tick();
    expect_a("t1_hold", 1'b0, 32'h0, 1'b1);
    check("t1_instr_out", 64'(bus_a.instr_out), 64'(D0));
    check("t1_instr_pc", 64'(bus_a.instr_pc), 64'd0);
    drive_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    tick();
    expect_a("t1_next", 1'b1, 32'h4, 1'b0);
    drive_a(1'b1, D1, 1'b0, 32'h0, 1'b1);
    exp_q.push_back({32'h4, D1});

    tick();
    expect_a("t2_hold", 1'b0, 32'h0, 1'b1);
    check("t2_instr_pc", 64'(bus_a.instr_pc), 64'h4);
    drive_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // three wait cycles before the ack at 8
    tick();
    expect_a("wait0", 1'b1, 32'h8, 1'b0);
    drive_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_a("wait", 1'b1, 32'h8, 1'b0);
    end
    tick();
    expect_a("wait_ack", 1'b1, 32'h8, 1'b0);
    drive_a(1'b1, D2, 1'b0, 32'h0, 1'b1);
    exp_q.push_back({32'h8, D2});

    tick();
    expect_a("t3_hold", 1'b0, 32'h0, 1'b1);
    check("t3_instr_out", 64'(bus_a.instr_out), 64'(D2));
    check("t3_instr_pc", 64'(bus_a.instr_pc), 64'h8);
    drive_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    tick();
    expect_a("t3_next", 1'b1, 32'hC, 1'b0);
    drive_a(1'b1, D3, 1'b0, 32'h0, 1'b0);
    exp_q.push_back({32'hC, D3});

    // decode stalls 4 cycles; a stray ack in HOLD must be ignored
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_a("stall", 1'b0, 32'h0, 1'b1);
      check("stall_instr_out", 64'(bus_a.instr_out), 64'(D3));
      check("stall_instr_pc", 64'(bus_a.instr_pc), 64'hC);
      drive_a(i == 1, JUNK, 1'b0, 32'h0, i == 4);
    end

    tick();
    expect_a("stall_next", 1'b1, 32'h10, 1'b0);
    drive_a(1'b0, 32'h0, 1'b1, 32'h103, 1'b0);

    // branch during pending fetch of 0x10
    tick();
    expect_a("drain0", 1'b1, 32'h10, 1'b0);
    check("drain_state", 64'(state_a), 64'd1);
    drive_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    expect_a("drain1", 1'b1, 32'h10, 1'b0);
    drive_a(1'b1, JUNK, 1'b0, 32'h0, 1'b1);

    tick();
    expect_a("redirect", 1'b1, 32'h100, 1'b0);
    check("redirect_state", 64'(state_a), 64'd0);
    drive_a(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);

    // second branch in DRAIN overwrites the parked target
    tick();
    expect_a("ovr0", 1'b1, 32'h100, 1'b0);
    drive_a(1'b0, 32'h0, 1'b1, 32'h302, 1'b0);
    tick();
    expect_a("ovr1", 1'b1, 32'h100, 1'b0);
    drive_a(1'b1, JUNK, 1'b0, 32'h0, 1'b0);

    tick();
    expect_a("ovr_done", 1'b1, 32'h300, 1'b0);
    drive_a(1'b1, JUNK, 1'b1, 32'h407, 1'b0);

    // ack and branch together in FETCH
    tick();
    expect_a("ackbr", 1'b1, 32'h404, 1'b0);
    check("ackbr_state", 64'(state_a), 64'd0);
    drive_a(1'b1, D4, 1'b0, 32'h0, 1'b0);

    // branch in HOLD wins over instr_ready
    tick();
    expect_a("holdbr", 1'b0, 32'h0, 1'b1);
    check("holdbr_instr_pc", 64'(bus_a.instr_pc), 64'h404);
    drive_a(1'b0, 32'h0, 1'b1, 32'h500, 1'b1);

    tick();
    expect_a("holdbr_next", 1'b1, 32'h500, 1'b0);
    drive_a(1'b0, 32'h0, 1'b1, 32'h600, 1'b0);

    // ack in DRAIN with a same-cycle branch uses the new target
    tick();
    expect_a("drainbr0", 1'b1, 32'h500, 1'b0);
    drive_a(1'b1, JUNK, 1'b1, 32'h701, 1'b0);
    tick();
    expect_a("drainbr1", 1'b1, 32'h700, 1'b0);
    check("drainbr_state", 64'(state_a), 64'd0);
    drive_a(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    tick();
    tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // second instance: reset vector 0xFFFFFFFC
    check("b_rst_req", 64'(bus_b.mem_req), 64'd0);
    rst_b = 1'b0;
    #1;
    check("b_first_req", 64'(bus_b.mem_req), 64'd1);
    check("b_first_addr", 64'(bus_b.mem_addr), 64'hFFFFFFFC);
    drive_b(1'b1, D5, 1'b0);

    tick();
    check("b_hold_valid", 64'(bus_b.instr_valid), 64'd1);
    check("b_hold_pc", 64'(bus_b.instr_pc), 64'hFFFFFFFC);
    check("b_hold_out", 64'(bus_b.instr_out), 64'(D5));
    check("b_hold_req", 64'(bus_b.mem_req), 64'd0);
    drive_b(1'b0, 32'h0, 1'b0);
    #2;
    rst_b = 1'b1;
    #1;
    check("b_rst_hold_valid", 64'(bus_b.instr_valid), 64'd0);
    check("b_rst_hold_req", 64'(bus_b.mem_req), 64'd0);
    check("b_rst_hold_out", 64'(bus_b.instr_out), 64'd0);
    check("b_rst_hold_state", 64'(state_b), 64'd0);

    tick();
    rst_b = 1'b0;
    #1;
    check("b_again_addr", 64'(bus_b.mem_addr), 64'hFFFFFFFC);
    drive_b(1'b1, D5, 1'b1);
    tick();
    check("b_again_valid", 64'(bus_b.instr_valid), 64'd1);
    check("b_again_pc", 64'(bus_b.instr_pc), 64'hFFFFFFFC);
    drive_b(1'b0, 32'h0, 1'b1);

    tick();
    check("b_wrap_req", 64'(bus_b.mem_req), 64'd1);
    check("b_wrap_addr", 64'(bus_b.mem_addr), 64'h0);
    check("b_wrap_valid", 64'(bus_b.instr_valid), 64'd0);
    #2;
    rst_b = 1'b1;
    #1;
    check("b_rst_wait_req", 64'(bus_b.mem_req), 64'd0);
    check("b_rst_wait_valid", 64'(bus_b.instr_valid), 64'd0);
    tick();
    rst_b = 1'b0;
    #1;
    check("b_final_addr", 64'(bus_b.mem_addr), 64'hFFFFFFFC);
    check("b_final_req", 64'(bus_b.mem_req), 64'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
